// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
// Latches an external interrupt request (rising edge), waits for control
// transfers to settle, freezes fetch and drains the pipeline with NOPs,
// steps the memory stage through a three-word push (PC low, PC high, CCR)
// and finally redirects the PC to VECTOR_ADDR with a one-cycle acknowledge.
// Optional build macro INT_MASK_EN adds an int_mask input that holds a
// pending request in IDLE while asserted.
module interrupt_sequencer #(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
`ifdef INT_MASK_EN
    input  logic        int_mask,
`endif
    input  logic [31:0] pc_current,
    input  logic [2:0]  ccr_in,
    input  logic        flush_busy,
    input  logic        call_active,
    output logic        fetch_stall,
    output logic        inject_nop,
    output logic        int_signal,
    output logic [1:0]  int_counter,
    output logic        push_pc,
    output logic        push_ccr,
    output logic [31:0] saved_pc,
    output logic [2:0]  saved_ccr,
    output logic        pc_load,
    output logic [31:0] pc_load_value,
    output logic        int_ack,
    output logic        int_pending
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        PUSH  = 2'd2,
        JUMP  = 2'd3
    } state_t;

    // Last value of the drain counter before moving on to the push sequence.
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [2:0] drain_cnt;
    logic       int_req_q;
    logic       pending;
    logic       req_rise;
    logic       masked;
    logic       start;

`ifdef INT_MASK_EN
    assign masked = int_mask;
`else
    assign masked = 1'b0;
`endif

    assign req_rise    = int_req & ~int_req_q;
    // Leaving IDLE uses the registered pending bit, so the edge that sets
    // pending can never start service in the same cycle.
    assign start       = (state == IDLE) & pending & ~flush_busy & ~call_active & ~masked;
    assign int_pending = pending;

    // Edge detector and pending latch; a fresh edge wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_req_q <= 1'b1;
            pending   <= 1'b0;
        end else begin
            int_req_q <= int_req;
            pending   <= req_rise | (pending & ~start);
        end
    end

    // Service FSM with registered (Moore) outputs computed for the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            drain_cnt     <= 3'd0;
            fetch_stall   <= 1'b0;
            inject_nop    <= 1'b0;
            int_signal    <= 1'b0;
            int_counter   <= 2'd0;
            push_pc       <= 1'b0;
            push_ccr      <= 1'b0;
            saved_pc      <= 32'h0;
            saved_ccr     <= 3'd0;
            pc_load       <= 1'b0;
            pc_load_value <= 32'h0;
            int_ack       <= 1'b0;
        end else begin
            pc_load       <= 1'b0;
            pc_load_value <= 32'h0;
            int_ack       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= DRAIN;
                        saved_pc    <= pc_current;
                        drain_cnt   <= 3'd0;
                        fetch_stall <= 1'b1;
                        inject_nop  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state       <= PUSH;
                        saved_ccr   <= ccr_in;
                        int_counter <= 2'd0;
                        int_signal  <= 1'b1;
                        push_pc     <= 1'b1;
                        push_ccr    <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                PUSH: begin
                    if (int_counter == 2'd2) begin
                        state         <= JUMP;
                        fetch_stall   <= 1'b0;
                        inject_nop    <= 1'b0;
                        int_signal    <= 1'b0;
                        int_counter   <= 2'd0;
                        push_pc       <= 1'b0;
                        push_ccr      <= 1'b0;
                        pc_load       <= 1'b1;
                        pc_load_value <= VECTOR_ADDR;
                        int_ack       <= 1'b1;
                    end else begin
                        int_counter <= int_counter + 2'd1;
                        push_pc     <= (int_counter == 2'd0);
                        push_ccr    <= (int_counter == 2'd1);
                    end
                end
                JUMP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios plus
// randomized traffic, all compared against a timeline-based service model.
module tb_interrupt_sequencer;

    localparam logic [31:0] VEC = 32'h0000_1F00;
    localparam int          D   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_req;
    logic        int_mask;
    logic [31:0] pc_current;
    logic [2:0]  ccr_in;
    logic        flush_busy;
    logic        call_active;
    logic        fetch_stall, inject_nop, int_signal, push_pc, push_ccr;
    logic [1:0]  int_counter;
    logic [31:0] saved_pc, pc_load_value;
    logic [2:0]  saved_ccr;
    logic        pc_load, int_ack, int_pending;

    int checks   = 0;
    int failures = 0;
    int acks     = 0;

    always #5 clk = ~clk;

    interrupt_sequencer #(.VECTOR_ADDR(VEC), .DRAIN_CYCLES(D)) dut (
        .clk(clk),
        .reset(reset),
        .int_req(int_req),
`ifdef INT_MASK_EN
        .int_mask(int_mask),
`endif
        .pc_current(pc_current),
        .ccr_in(ccr_in),
        .flush_busy(flush_busy),
        .call_active(call_active),
        .fetch_stall(fetch_stall),
        .inject_nop(inject_nop),
        .int_signal(int_signal),
        .int_counter(int_counter),
        .push_pc(push_pc),
        .push_ccr(push_ccr),
        .saved_pc(saved_pc),
        .saved_ccr(saved_ccr),
        .pc_load(pc_load),
        .pc_load_value(pc_load_value),
        .int_ack(int_ack),
        .int_pending(int_pending)
    );

    // Reference model: a service is a fixed timeline of D drain cycles,
    // three push cycles and one jump cycle; m_step is the position in it.
    int          m_step;
    bit          m_pending;
    bit          m_req_prev;
    logic [31:0] m_pc;
    logic [2:0]  m_ccr;

    function automatic void model_reset();
        m_step     = -1;
        m_pending  = 1'b0;
        m_req_prev = 1'b1;
        m_pc       = 32'h0;
        m_ccr      = 3'd0;
    endfunction

    function automatic void model_edge();
        bit rise, start, mask_eff;
`ifdef INT_MASK_EN
        mask_eff = int_mask;
`else
        mask_eff = 1'b0;
`endif
        rise  = int_req && !m_req_prev;
        start = (m_step < 0) && m_pending && !flush_busy && !call_active && !mask_eff;
        if (start) begin
            m_pc   = pc_current;
            m_step = 0;
        end else if (m_step >= 0) begin
            m_step++;
            if (m_step == D) m_ccr = ccr_in;
            if (m_step > D + 3) m_step = -1;
        end
        m_pending  = rise || (m_pending && !start);
        m_req_prev = int_req;
    endfunction

    function automatic logic [76:0] exp_vec();
        bit drn, psh, jmp;
        logic [1:0] cnt;
        drn = (m_step >= 0) && (m_step < D);
        psh = (m_step >= D) && (m_step < D + 3);
        jmp = (m_step == D + 3);
        cnt = psh ? 2'(m_step - D) : 2'd0;
        return {drn | psh, drn | psh, psh, cnt, psh && (cnt != 2'd2), psh && (cnt == 2'd2),
                m_pc, m_ccr, jmp, (jmp ? VEC : 32'h0), jmp, m_pending};
    endfunction

    function automatic logic [76:0] obs_vec();
        return {fetch_stall, inject_nop, int_signal, int_counter, push_pc, push_ccr,
                saved_pc, saved_ccr, pc_load, pc_load_value, int_ack, int_pending};
    endfunction

    // Advance one clock, update the model with the pre-edge inputs, settle.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        if (int_ack === 1'b1) acks++;
    endtask

    task automatic test_reset();
        reset = 1'b1; int_req = 1'b1; int_mask = 1'b0; pc_current = 32'h0;
        ccr_in = 3'd0; flush_busy = 1'b0; call_active = 1'b0;
        model_reset();
        tick();
        tick();
        checks++;
        if (obs_vec() !== 77'h0) begin
            failures++;
            $display("FAIL reset_state: got %h expected 0", obs_vec());
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_release cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (int_pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_held_req_pending: got %b expected 0", int_pending);
        end
        int_req = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int a0;
        a0 = acks;
        pc_current = 32'h0000_0120; ccr_in = 3'b101;
        int_req = 1'b1;
        tick();
        checks++;
        if (int_pending !== 1'b1) begin
            failures++;
            $display("FAIL basic_pending: got %b expected 1", int_pending);
        end
        int_req = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 2) pc_current = 32'hDEAD_0000;
            if (i == 5) ccr_in = 3'b010;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL basic cycle E%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (saved_pc !== 32'h0000_0120 || saved_ccr !== 3'b101 || (acks - a0) != 1) begin
            failures++;
            $display("FAIL basic_capture: got pc=%h ccr=%b acks=%0d expected pc=120 ccr=101 acks=1",
                     saved_pc, saved_ccr, acks - a0);
        end
    endtask

    task automatic test_deferral();
        for (int sel = 0; sel < 2; sel++) begin
            if (sel == 0) flush_busy = 1'b1;
            else call_active = 1'b1;
            pc_current = 32'h0000_4000 + 32'(sel);
            int_req = 1'b1;
            tick();
            int_req = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if (fetch_stall !== 1'b0 || int_pending !== 1'b1) begin
                    failures++;
                    $display("FAIL deferral%0d hold %0d: got stall=%b pend=%b expected stall=0 pend=1",
                             sel, i, fetch_stall, int_pending);
                end
            end
            flush_busy = 1'b0; call_active = 1'b0;
            tick();
            checks++;
            if (fetch_stall !== 1'b1 || saved_pc !== 32'h0000_4000 + 32'(sel)) begin
                failures++;
                $display("FAIL deferral%0d start: got stall=%b pc=%h expected stall=1 pc=%h",
                         sel, fetch_stall, saved_pc, 32'h0000_4000 + 32'(sel));
            end
            for (int i = 0; i < 8; i++) begin
                tick();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL deferral%0d cycle %0d: got %h expected %h", sel, i, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_collapse();
        int a0;
        int n;
        a0 = acks;
        int_req = 1'b1; tick();
        int_req = 1'b0; tick();
        n = 0;
        while (int_signal !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (int_signal !== 1'b1) begin
            failures++;
            $display("FAIL collapse_reach_push: got int_signal=%b expected 1 within 20 cycles", int_signal);
        end
        int_req = 1'b1; tick();
        int_req = 1'b0; tick();
        int_req = 1'b1; tick();
        int_req = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL collapse cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (acks - a0 != 2) begin
            failures++;
            $display("FAIL collapse_ack_count: got %0d expected 2", acks - a0);
        end
    endtask

    task automatic test_level_hold();
        int a0;
        a0 = acks;
        int_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) int_req = 1'b0;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL level_hold cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (acks - a0 != 1) begin
            failures++;
            $display("FAIL level_hold_ack_count: got %0d expected 1", acks - a0);
        end
    endtask

    task automatic test_async_reset();
        int n;
        int_req = 1'b1; tick();
        int_req = 1'b0; tick();
        n = 0;
        while (!(int_signal === 1'b1 && int_counter === 2'd1) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (int_counter !== 2'd1) begin
            failures++;
            $display("FAIL async_reach_push1: got int_counter=%0d expected 1 within 20 cycles", int_counter);
        end
        #1 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== 77'h0) begin
            failures++;
            $display("FAIL async_reset_outputs: got %h expected 0", obs_vec());
        end
        tick();
        checks++;
        if (pc_load !== 1'b0 || fetch_stall !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_hold: got pc_load=%b stall=%b expected 0 0", pc_load, fetch_stall);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL async_after cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef INT_MASK_EN
    task automatic test_mask();
        int_mask = 1'b1;
        int_req = 1'b1; tick();
        int_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (fetch_stall !== 1'b0 || int_pending !== 1'b1) begin
                failures++;
                $display("FAIL mask_hold %0d: got stall=%b pend=%b expected 0 1", i, fetch_stall, int_pending);
            end
        end
        int_mask = 1'b0;
        tick();
        checks++;
        if (fetch_stall !== 1'b1) begin
            failures++;
            $display("FAIL mask_release: got stall=%b expected 1", fetch_stall);
        end
        int_mask = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL mask_inflight cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        int_mask = 1'b0;
        tick();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) int_req = ~int_req;
            flush_busy  = ($urandom_range(0, 9) < 3);
            call_active = ($urandom_range(0, 9) < 2);
`ifdef INT_MASK_EN
            int_mask    = ($urandom_range(0, 9) < 2);
`endif
            pc_current  = $urandom;
            ccr_in      = 3'($urandom_range(0, 7));
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        int_req = 1'b0; flush_busy = 1'b0; call_active = 1'b0; int_mask = 1'b0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_deferral();
        test_collapse();
        test_level_hold();
        test_async_reset();
`ifdef INT_MASK_EN
        test_mask();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
